// File: rtl/time_keeper_ctrl_pkg.sv
// Shared types and constants for the time keeper controller.
// Optional feature macro used by the top: ALARM_AUTO_OFF_EN.
package time_keeper_ctrl_pkg;

  typedef enum logic [1:0] {
    SHOW_TIME  = 2'b00,
    ENTRY      = 2'b01,
    SHOW_ALARM = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SHOW_TIME  = 2'b00;
  localparam logic [1:0] MODE_ENTRY      = 2'b01;
  localparam logic [1:0] MODE_SHOW_ALARM = 2'b10;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  // True when a 4-bit nibble is a decimal digit 0-9.
  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/time_keeper_ctrl_bcd_time_inc.sv
// bcd_time_inc: BCD HH:MM validity check and optional one-minute increment.
// time_out is time_in advanced by one minute when inc_en=1, else time_in.
module bcd_time_inc
  import time_keeper_ctrl_pkg::*;
(
  input  logic [15:0] time_in,
  input  logic        inc_en,
  output logic [15:0] time_out,
  output logic        time_valid
);

  localparam bcd_digit_t MIN_TENS_MAX  = 4'(MAX_MIN / 10);
  localparam bcd_digit_t MIN_UNITS_MAX = 4'(MAX_MIN % 10);
  localparam bcd_digit_t HR_TENS_MAX   = 4'(MAX_HOUR / 10);
  localparam bcd_digit_t HR_UNITS_MAX  = 4'(MAX_HOUR % 10);

  bcd_digit_t h1, h0, m1, m0;
  bcd_digit_t nh1, nh0, nm1, nm0;
  logic [6:0] hours, mins;

  assign {h1, h0, m1, m0} = time_in;

  // Range check: every nibble a digit, hours and minutes within limits.
  always_comb begin
    hours      = 7'({3'b000, h1} * 7'd10) + {3'b000, h0};
    mins       = 7'({3'b000, m1} * 7'd10) + {3'b000, m0};
    time_valid = is_bcd_digit(h1) && is_bcd_digit(h0) &&
                 is_bcd_digit(m1) && is_bcd_digit(m0) &&
                 (hours <= 7'(MAX_HOUR)) && (mins <= 7'(MAX_MIN));
  end

  // Ripple BCD increment: M0 -> M1 -> hours, wrapping 23:59 to 00:00.
  always_comb begin
    nh1 = h1;
    nh0 = h0;
    nm1 = m1;
    nm0 = m0;
    if (m0 != MIN_UNITS_MAX) begin
      nm0 = m0 + 4'd1;
    end else begin
      nm0 = '0;
      if (m1 != MIN_TENS_MAX) begin
        nm1 = m1 + 4'd1;
      end else begin
        nm1 = '0;
        if (h1 == HR_TENS_MAX && h0 == HR_UNITS_MAX) begin
          nh1 = '0;
          nh0 = '0;
        end else if (h0 == 4'd9) begin
          nh0 = '0;
          nh1 = h1 + 4'd1;
        end else begin
          nh0 = h0 + 4'd1;
        end
      end
    end
    time_out = inc_en ? {nh1, nh0, nm1, nm0} : time_in;
  end

endmodule

// File: rtl/time_keeper_ctrl.sv
// time_keeper_ctrl: alarm-clock controller with key entry of time/alarm.
// Define ALARM_AUTO_OFF_EN to silence the alarm after 60 one_second pulses.
module time_keeper_ctrl
  import time_keeper_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 10,
  parameter int unsigned TO_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        one_minute,
  input  logic        key_valid,
  input  logic [3:0]  key,
  input  logic        time_button,
  input  logic        alarm_button,
  input  logic        fast_watch,
  output logic        stopwatch,
  output logic [15:0] cur_time,
  output logic [15:0] alarm_time,
  output logic [15:0] disp,
  output logic [1:0]  mode,
  output logic        alarm_sound
);

  state_t            state, state_next;
  logic [15:0]       buffer;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       commit_word, cur_inc;
  logic              buf_valid, cur_valid;
  logic              key_ok, minute_tick;
  logic              commit_time, commit_alarm, buf_first, buf_shift, to_inc;
  logic              snd_set, snd_clr, snd_auto_off;

  assign key_ok      = key_valid && is_bcd_digit(key);
  assign minute_tick = one_minute && cur_valid;
  assign mode        = state;

  bcd_time_inc u_buf_chk (
    .time_in    (buffer),
    .inc_en     (1'b0),
    .time_out   (commit_word),
    .time_valid (buf_valid)
  );

  bcd_time_inc u_cur_inc (
    .time_in    (cur_time),
    .inc_en     (1'b1),
    .time_out   (cur_inc),
    .time_valid (cur_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SHOW_TIME;
    else       state <= state_next;
  end

  // Next-state and entry/commit decode.
  always_comb begin
    state_next   = state;
    commit_time  = 1'b0;
    commit_alarm = 1'b0;
    buf_first    = 1'b0;
    buf_shift    = 1'b0;
    to_inc       = 1'b0;
    unique case (state)
      SHOW_TIME: begin
        if (key_ok) begin
          state_next = ENTRY;
          buf_first  = 1'b1;
        end else if (alarm_button) begin
          state_next = SHOW_ALARM;
        end
      end
      ENTRY: begin
        if (time_button) begin
          commit_time = buf_valid;
          state_next  = SHOW_TIME;
        end else if (alarm_button) begin
          commit_alarm = buf_valid;
          state_next   = SHOW_TIME;
        end else if (key_ok) begin
          buf_shift = 1'b1;
        end else if (one_second) begin
          if (to_cnt == TO_W'(TIMEOUT - 1)) state_next = SHOW_TIME;
          else                              to_inc     = 1'b1;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
      end
      default: state_next = SHOW_TIME;
    endcase
  end

  // Entry buffer and inactivity counter; both discarded on leaving ENTRY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer <= '0;
      to_cnt <= '0;
    end else if (buf_first) begin
      buffer <= {12'h000, key};
      to_cnt <= '0;
    end else if (buf_shift) begin
      buffer <= {buffer[11:0], key};
      to_cnt <= '0;
    end else if (to_inc) begin
      to_cnt <= to_cnt + 1'b1;
    end else if (state_next != ENTRY) begin
      buffer <= '0;
      to_cnt <= '0;
    end
  end

  // Current and alarm time; a commit overrides a coincident minute tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_time   <= '0;
      alarm_time <= '0;
    end else begin
      if (commit_time)      cur_time <= commit_word;
      else if (minute_tick) cur_time <= cur_inc;
      if (commit_alarm)     alarm_time <= commit_word;
    end
  end

  assign snd_set = minute_tick && !commit_time && (cur_inc == alarm_time);
  assign snd_clr = alarm_button && (state == SHOW_TIME || state == SHOW_ALARM);

`ifdef ALARM_AUTO_OFF_EN
  logic [5:0] snd_cnt;

  assign snd_auto_off = alarm_sound && one_second && (snd_cnt == 6'd59);

  // Seconds elapsed since the alarm last started sounding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         snd_cnt <= '0;
    else if (snd_set)                  snd_cnt <= '0;
    else if (alarm_sound && one_second) snd_cnt <= snd_cnt + 6'd1;
  end
`else
  assign snd_auto_off = 1'b0;
`endif

  // Alarm flag: clear beats set, set beats auto-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             alarm_sound <= 1'b0;
    else if (snd_clr)      alarm_sound <= 1'b0;
    else if (snd_set)      alarm_sound <= 1'b1;
    else if (snd_auto_off) alarm_sound <= 1'b0;
  end

  // Stopwatch request to the time generator, one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stopwatch <= 1'b0;
    else       stopwatch <= fast_watch;
  end

  // Display word selection.
  always_comb begin
    unique case (state)
      ENTRY:      disp = buffer;
      SHOW_ALARM: disp = alarm_time;
      default:    disp = cur_time;
    endcase
  end

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// Self-checking bench for time_keeper_ctrl (table-driven plus corner sequences).
module tb_time_keeper_ctrl;

  localparam int unsigned TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        reset, one_second, one_minute, key_valid, time_button, alarm_button, fast_watch;
  logic [3:0]  key;
  logic        stopwatch, alarm_sound;
  logic [15:0] cur_time, alarm_time, disp;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  k;
    logic        tb, ab, os, om;
    logic [1:0]  md;
    logic [15:0] cur, alm, dsp;
    logic        snd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  time_keeper_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .one_minute   (one_minute),
    .key_valid    (key_valid),
    .key          (key),
    .time_button  (time_button),
    .alarm_button (alarm_button),
    .fast_watch   (fast_watch),
    .stopwatch    (stopwatch),
    .cur_time     (cur_time),
    .alarm_time   (alarm_time),
    .disp         (disp),
    .mode         (mode),
    .alarm_sound  (alarm_sound)
  );

  function automatic vec_t v(input logic kv, input logic [3:0] k, input logic tb, input logic ab,
                             input logic os, input logic om, input logic [1:0] md,
                             input logic [15:0] cur, input logic [15:0] alm,
                             input logic [15:0] dsp, input logic snd);
    vec_t r;
    r.kv = kv; r.k = k; r.tb = tb; r.ab = ab; r.os = os; r.om = om;
    r.md = md; r.cur = cur; r.alm = alm; r.dsp = dsp; r.snd = snd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic kv, input logic [3:0] k, input logic tb, input logic ab,
                      input logic os, input logic om);
    key_valid = kv; key = k; time_button = tb; alarm_button = ab;
    one_second = os; one_minute = om;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_valid = 1'b0; key = 4'd0; time_button = 1'b0; alarm_button = 1'b0;
    one_second = 1'b0; one_minute = 1'b0; fast_watch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, m;
    logic [15:0] exp_t;

    // Reset state, checked while reset is still asserted.
    reset = 1'b1;
    key_valid = 1'b0; key = 4'd0; time_button = 1'b0; alarm_button = 1'b0;
    one_second = 1'b0; one_minute = 1'b0; fast_watch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", 16'(mode), 16'h0000);
    chk("rst_cur", cur_time, 16'h0000);
    chk("rst_alarm", alarm_time, 16'h0000);
    chk("rst_disp", disp, 16'h0000);
    chk("rst_snd", 16'(alarm_sound), 16'h0000);
    chk("rst_stopwatch", 16'(stopwatch), 16'h0000);
    reset = 1'b0;

    // Full day of minute pulses against an independent HH:MM model.
    h = 0; m = 0;
    for (int i = 0; i < 1440; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      m++;
      if (m == 60) begin m = 0; h++; end
      if (h == 24) h = 0;
      exp_t = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
      chk("minute_sweep", cur_time, exp_t);
    end
    chk("sweep_end", cur_time, 16'h0000);
    chk("sweep_wrap_alarm", 16'(alarm_sound), 16'h0001);

    // Directed table: one clock per row, all visible outputs compared.
    do_reset();
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0001, 0));
    vecs.push_back(v(1, 2, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0012, 0));
    vecs.push_back(v(1, 3, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0123, 0));
    vecs.push_back(v(1, 4, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h1234, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 'h1234, 'h0000, 'h1234, 0));
    vecs.push_back(v(1, 2, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0002, 0));
    vecs.push_back(v(1, 5, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0025, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0250, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h2500, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 'h1234, 'h0000, 'h1234, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0000, 0));
    vecs.push_back(v(1, 7, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0007, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0070, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1234, 'h0000, 'h0700, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 'h1234, 'h0700, 'h1234, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 2, 'h1234, 'h0700, 'h0700, 0));
    vecs.push_back(v(1, 5, 0, 1, 0, 0, 2, 'h1234, 'h0700, 'h0700, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 'h1234, 'h0700, 'h1234, 0));
    vecs.push_back(v(1, 12, 0, 0, 0, 0, 0, 'h1234, 'h0700, 'h1234, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1234, 'h0700, 'h0000, 0));
    vecs.push_back(v(1, 6, 0, 0, 0, 0, 1, 'h1234, 'h0700, 'h0006, 0));
    vecs.push_back(v(1, 5, 0, 0, 0, 0, 1, 'h1234, 'h0700, 'h0065, 0));
    vecs.push_back(v(1, 9, 0, 0, 0, 0, 1, 'h1234, 'h0700, 'h0659, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 'h0659, 'h0700, 'h0659, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 'h0700, 'h0700, 'h0700, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 'h0700, 'h0700, 'h0700, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 2, 'h0700, 'h0700, 'h0700, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 'h0700, 'h0700, 'h0700, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 'h0701, 'h0700, 'h0701, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 'h0701, 'h0700, 'h0001, 0));
    vecs.push_back(v(1, 10, 0, 0, 0, 0, 1, 'h0701, 'h0700, 'h0001, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h0701, 'h0700, 'h0010, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 'h0702, 'h0700, 'h0010, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h0702, 'h0700, 'h0100, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h0702, 'h0700, 'h1000, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 0, 'h1000, 'h0700, 'h1000, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1000, 'h0700, 'h0000, 0));
    vecs.push_back(v(1, 7, 0, 0, 0, 0, 1, 'h1000, 'h0700, 'h0007, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1000, 'h0700, 'h0070, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h1000, 'h0700, 'h0700, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 'h0700, 'h0700, 'h0700, 0));
    vecs.push_back(v(1, 3, 0, 1, 0, 0, 1, 'h0700, 'h0700, 'h0003, 0));
    vecs.push_back(v(1, 9, 0, 0, 0, 0, 1, 'h0700, 'h0700, 'h0039, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 'h0700, 'h0039, 'h0700, 0));
    vecs.push_back(v(1, 2, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h0002, 0));
    vecs.push_back(v(1, 3, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h0023, 0));
    vecs.push_back(v(1, 6, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h0236, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h2360, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 'h0700, 'h0039, 'h0700, 0));
    vecs.push_back(v(1, 2, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h0002, 0));
    vecs.push_back(v(1, 3, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h0023, 0));
    vecs.push_back(v(1, 5, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h0235, 0));
    vecs.push_back(v(1, 9, 0, 0, 0, 0, 1, 'h0700, 'h0039, 'h2359, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 'h2359, 'h0039, 'h2359, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 'h0000, 'h0039, 'h0000, 0));

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].k, vecs[i].tb, vecs[i].ab, vecs[i].os, vecs[i].om);
      chk($sformatf("row%0d_mode", i), 16'(mode), 16'(vecs[i].md));
      chk($sformatf("row%0d_cur", i), cur_time, vecs[i].cur);
      chk($sformatf("row%0d_alarm", i), alarm_time, vecs[i].alm);
      chk($sformatf("row%0d_disp", i), disp, vecs[i].dsp);
      chk($sformatf("row%0d_snd", i), 16'(alarm_sound), 16'(vecs[i].snd));
    end

    // Entry abandoned after TIMEOUT one_second pulses with no keys.
    press(4'd5);
    chk("to_enter", 16'(mode), 16'h0001);
    for (int p = 1; p <= int'(TIMEOUT); p++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("to_pulse%0d_mode", p), 16'(mode), (p < int'(TIMEOUT)) ? 16'h0001 : 16'h0000);
      idle();
    end
    chk("to_cur", cur_time, 16'h0000);
    chk("to_alarm", alarm_time, 16'h0039);
    chk("to_disp", disp, 16'h0000);

    // Alarm set, then 60 one_second pulses.
    press(4'd0); press(4'd8); press(4'd0); press(4'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ao_alarm", alarm_time, 16'h0800);
    press(4'd0); press(4'd7); press(4'd5); press(4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ao_cur", cur_time, 16'h0759);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ao_set", 16'(alarm_sound), 16'h0001);
    for (int p = 1; p <= 59; p++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
    end
    chk("ao_59", 16'(alarm_sound), 16'h0001);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALARM_AUTO_OFF_EN
    chk("ao_60", 16'(alarm_sound), 16'h0000);
`else
    chk("ao_60", 16'(alarm_sound), 16'h0001);
`endif
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ao_clear_mode", 16'(mode), 16'h0002);
    chk("ao_clear_snd", 16'(alarm_sound), 16'h0000);
    idle();
    chk("ao_back_mode", 16'(mode), 16'h0000);

    // Asynchronous reset in the middle of entry: nothing is committed.
    press(4'd1); press(4'd2);
    chk("mr_mode_entry", 16'(mode), 16'h0001);
    reset = 1'b1;
    #2;
    chk("mr_mode", 16'(mode), 16'h0000);
    chk("mr_cur", cur_time, 16'h0000);
    chk("mr_disp", disp, 16'h0000);
    reset = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mr_commit_cur", cur_time, 16'h0000);
    chk("mr_commit_mode", 16'(mode), 16'h0000);

    // Stopwatch follows fast_watch one cycle later.
    fast_watch = 1'b1;
    chk("sw_before", 16'(stopwatch), 16'h0000);
    idle();
    chk("sw_on", 16'(stopwatch), 16'h0001);
    fast_watch = 1'b0;
    idle();
    chk("sw_off", 16'(stopwatch), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper_ctrl.md
TIME_KEEPER_CTRL -- requirements
Module: time_keeper_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 10: one_second pulses of key inactivity before key entry is abandoned.
REQ-002 Parameter TO_W, default 4: timeout counter width; TIMEOUT SHALL fit in TO_W bits.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 one_second  in  1  one-cycle pulse per second from the time generator.
REQ-006 one_minute  in  1  one-cycle pulse per minute (per second while stopwatch=1) from the time generator.
REQ-007 key_valid  in  1  one-cycle strobe qualifying key.
REQ-008 key  in  4  BCD digit 0-9; values 10-15 ignored.
REQ-009 time_button  in  1  level; commit entered digits as current time.
REQ-010 alarm_button  in  1  level; commit as alarm time, or view alarm / silence alarm.
REQ-011 fast_watch  in  1  request fast time advance.
REQ-012 stopwatch  out  1  registered copy of fast_watch, drives time generator.
REQ-013 cur_time  out  16  current time, BCD {H1,H0,M1,M0}.
REQ-014 alarm_time  out  16  alarm time, same BCD format.
REQ-015 disp  out  16  display word selected by state.
REQ-016 mode  out  2  00 SHOW_TIME, 01 ENTRY, 10 SHOW_ALARM.
REQ-017 alarm_sound  out  1  alarm active.

Function
REQ-018 FSM states SHOW_TIME, ENTRY, SHOW_ALARM; mode SHALL equal the state encoding, registered.
REQ-019 SHOW_TIME: key_valid with digit <=9 -> ENTRY, buffer = {12'h000, key}; alarm_button=1 -> SHOW_ALARM (also clears alarm_sound); key takes priority if both.
REQ-020 SHOW_ALARM: stays while alarm_button=1; returns to SHOW_TIME the cycle after alarm_button=0; keys ignored.
REQ-021 ENTRY: each valid digit shifts buffer left 4 bits, new digit in [3:0], timeout counter cleared.
REQ-022 ENTRY: time_button=1 -> cur_time <= buffer if H<=23 and M<=59, else discarded; -> SHOW_TIME.
REQ-023 ENTRY: alarm_button=1 (time_button=0) -> alarm_time <= buffer under same validity rule; -> SHOW_TIME.
REQ-024 ENTRY: timeout counter increments per one_second; on reaching TIMEOUT -> SHOW_TIME, buffer discarded.
REQ-025 disp = buffer in ENTRY, alarm_time in SHOW_ALARM, cur_time otherwise, combinational from state.
REQ-026 Each one_minute pulse increments cur_time in BCD: M0 9->0 carries M1; M 59->00 carries H; 23:59 -> 00:00.
REQ-027 A commit to cur_time in the same cycle as one_minute SHALL win; the increment is dropped.
REQ-028 alarm_sound SHALL set the cycle after an increment makes cur_time equal alarm_time; a commit making them equal SHALL NOT set it.
REQ-029 alarm_sound clears on alarm_button=1 in SHOW_TIME or SHOW_ALARM; clear wins over simultaneous set.
REQ-030 stopwatch <= fast_watch each cycle (one-cycle latency).

Reset
REQ-031 reset SHALL force state SHOW_TIME, cur_time 16'h0000, alarm_time 16'h0000, buffer 0, timeout counter 0, stopwatch 0, alarm_sound 0, mode 00, disp 16'h0000.
REQ-032 reset mid-ENTRY SHALL discard the buffer; no partial commit.

Configuration
REQ-033 Macro ALARM_AUTO_OFF_EN defined: alarm_sound additionally clears after 60 one_second pulses while set (6-bit counter cleared at set).
REQ-034 Macro ALARM_AUTO_OFF_EN undefined: alarm_sound clears only per REQ-029; no counter instantiated.

Structure
REQ-035 Shared package SHALL hold the state enum, mode codes, BCD digit type, and constants MAX_HOUR=23, MAX_MIN=59.
REQ-036 The BCD HH:MM increment/validity logic SHALL be one sub-module, bcd_time_inc, used by the cur_time path and commit checks.

Verification
REQ-037 reset, 1440 one_minute pulses from 00:00 -> cur_time passes 00:59->01:00, 23:59->00:00, ends 16'h0000.
REQ-038 keys 1,2,3,4 then time_button -> cur_time=16'h1234 next cycle, mode 00; keys 2,5,0,0 then time_button -> cur_time unchanged.
REQ-039 keys 0,7,0,0 then alarm_button; cur_time 06:59, one_minute -> alarm_sound=1 next cycle; alarm_button -> 0.
REQ-040 key 5 then TIMEOUT one_second pulses without keys -> mode 00, cur_time/alarm_time unchanged, disp=cur_time.
REQ-041 time_button commit 16'h1000 coinciding with one_minute -> cur_time=16'h1000, not 10:01.
REQ-042 With ALARM_AUTO_OFF_EN: alarm set, 60 one_second pulses -> alarm_sound=0; without: stays 1.
